// File: rtl/axis_drop_policy.sv
// axis_drop_policy
// Per-port congestion policer feeding axis_dropper. Each port compares its
// downstream FIFO fill level against high/low watermarks with hysteresis,
// keeps drop asserted for a programmable hold time after draining, and
// counts congestion episodes (PASS->DROP transitions).
// policy_state encoding per port: 0 PASS, 1 DROP, 2 HOLD.
module axis_drop_policy #(
    parameter int unsigned PORT_COUNT    = 4,
    parameter int unsigned LVL_WIDTH     = 16,
    parameter int unsigned HOLD_WIDTH    = 16,
    parameter int unsigned EVT_CNT_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PORT_COUNT-1:0]               cfg_enable,
    input  logic [PORT_COUNT-1:0]               cfg_force_drop,
    input  logic [PORT_COUNT*LVL_WIDTH-1:0]     cfg_high,
    input  logic [PORT_COUNT*LVL_WIDTH-1:0]     cfg_low,
    input  logic [HOLD_WIDTH-1:0]               cfg_hold,
    input  logic [PORT_COUNT*LVL_WIDTH-1:0]     fifo_level,
    output logic [PORT_COUNT-1:0]               drop,
    output logic [PORT_COUNT*2-1:0]             policy_state,
    output logic [PORT_COUNT*EVT_CNT_WIDTH-1:0] episode_count
);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_DROP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    genvar g;
    for (g = 0; g < PORT_COUNT; g++) begin : g_port

        logic [LVL_WIDTH-1:0]     level;
        logic [LVL_WIDTH-1:0]     high_wm;
        logic [LVL_WIDTH-1:0]     low_wm;
        logic                     at_high;
        logic                     at_low;

        state_t                   state_q;
        state_t                   state_d;
        logic [HOLD_WIDTH-1:0]    timer_q;
        logic [HOLD_WIDTH-1:0]    timer_d;
        logic                     episode_inc;
        logic [EVT_CNT_WIDTH-1:0] count_q;
        logic                     drop_q;

        assign level   = fifo_level[g*LVL_WIDTH +: LVL_WIDTH];
        assign high_wm = cfg_high[g*LVL_WIDTH +: LVL_WIDTH];
        assign low_wm  = cfg_low[g*LVL_WIDTH +: LVL_WIDTH];

        // Unsigned full-width watermark compares; low >= high is allowed and
        // simply lets the port oscillate between PASS and DROP.
        assign at_high = (level >= high_wm);
        assign at_low  = (level <= low_wm);

        // Next-state and hold-timer logic; disable overrides every state.
        always_comb begin
            state_d     = state_q;
            timer_d     = timer_q;
            episode_inc = 1'b0;
            if (!cfg_enable[g]) begin
                state_d = ST_PASS;
                timer_d = '0;
            end else begin
                case (state_q)
                    ST_PASS: begin
                        if (at_high) begin
                            state_d     = ST_DROP;
                            episode_inc = 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (at_low) begin
                            if (cfg_hold == '0) begin
                                state_d = ST_PASS;
                            end else begin
                                // cfg_hold is captured only here, so later
                                // reprogramming never stretches a running hold.
                                state_d = ST_HOLD;
                                timer_d = cfg_hold;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (at_high) begin
                            // Re-congestion during hold continues the same
                            // episode; no count increment.
                            state_d = ST_DROP;
                            timer_d = '0;
                        end else if (timer_q == HOLD_WIDTH'(1)) begin
                            state_d = ST_PASS;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - HOLD_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d = ST_PASS;
                        timer_d = '0;
                    end
                endcase
            end
        end

        // State, timer, episode counter and registered drop request.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_PASS;
                timer_q <= '0;
                count_q <= '0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                if (episode_inc) begin
                    count_q <= count_q + EVT_CNT_WIDTH'(1);
                end
                // Force-drop only widens the request; it never touches state.
                drop_q <= (state_d != ST_PASS) | cfg_force_drop[g];
            end
        end

        assign drop[g]                                          = drop_q;
        assign policy_state[g*2 +: 2]                           = state_q;
        assign episode_count[g*EVT_CNT_WIDTH +: EVT_CNT_WIDTH]  = count_q;

    end

endmodule

// File: tb/tb_axis_drop_policy.sv
// Self-checking bench for axis_drop_policy: directed scenarios plus a random
// walk, all checked against a behavioural per-port model. A second instance
// with a 3-bit episode counter shares the stimulus to exercise counter wrap.
module tb_axis_drop_policy;

    localparam int NP  = 4;
    localparam int LW  = 16;
    localparam int CW  = 32;
    localparam int CWS = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     en  = '0;
    logic [NP-1:0]     frc = '0;
    logic [NP*LW-1:0]  hi  = '0;
    logic [NP*LW-1:0]  lo  = '0;
    logic [NP*LW-1:0]  lvl = '0;
    logic [15:0]       hold = '0;

    logic [NP-1:0]     drop, drop_s;
    logic [NP*2-1:0]   pstate, pstate_s;
    logic [NP*CW-1:0]  ecount;
    logic [NP*CWS-1:0] ecount_s;

    logic [NP-1:0]     exp_drop;
    logic [NP*2-1:0]   exp_state;
    logic [NP*CW-1:0]  exp_cnt;
    logic [NP*CWS-1:0] exp_cnt_s;

    int          m_st  [NP];
    int unsigned m_tmr [NP];
    int unsigned m_cnt [NP];
    bit          m_drop[NP];

    int n_cmp = 0;
    int n_bad = 0;

    axis_drop_policy #(
        .PORT_COUNT(NP), .LVL_WIDTH(LW), .HOLD_WIDTH(16), .EVT_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_enable(en), .cfg_force_drop(frc),
        .cfg_high(hi), .cfg_low(lo), .cfg_hold(hold), .fifo_level(lvl),
        .drop(drop), .policy_state(pstate), .episode_count(ecount)
    );

    axis_drop_policy #(
        .PORT_COUNT(NP), .LVL_WIDTH(LW), .HOLD_WIDTH(16), .EVT_CNT_WIDTH(CWS)
    ) dut_s (
        .clk(clk), .rst(rst), .cfg_enable(en), .cfg_force_drop(frc),
        .cfg_high(hi), .cfg_low(lo), .cfg_hold(hold), .fifo_level(lvl),
        .drop(drop_s), .policy_state(pstate_s), .episode_count(ecount_s)
    );

    always #5 clk = ~clk;

    // Advance one clock; apply the policy rules to the inputs seen at that edge.
    task automatic step();
        int          ns;
        int unsigned l, h, w;
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            l  = lvl[p*LW +: LW];
            h  = hi[p*LW +: LW];
            w  = lo[p*LW +: LW];
            ns = m_st[p];
            if (rst) begin
                m_st[p] = 0; m_tmr[p] = 0; m_cnt[p] = 0; m_drop[p] = 0;
                continue;
            end
            if (!en[p]) begin
                ns = 0; m_tmr[p] = 0;
            end else if (m_st[p] == 0) begin
                if (l >= h) begin ns = 1; m_cnt[p] = m_cnt[p] + 1; end
            end else if (m_st[p] == 1) begin
                if (l <= w) begin
                    if (hold == 0) ns = 0;
                    else begin ns = 2; m_tmr[p] = hold; end
                end
            end else begin
                if (l >= h) begin ns = 1; m_tmr[p] = 0; end
                else if (m_tmr[p] == 1) begin ns = 0; m_tmr[p] = 0; end
                else m_tmr[p] = m_tmr[p] - 1;
            end
            m_st[p]   = ns;
            m_drop[p] = (ns != 0) || frc[p];
        end
        for (int p = 0; p < NP; p++) begin
            exp_drop[p]            = m_drop[p];
            exp_state[p*2 +: 2]    = 2'(m_st[p]);
            exp_cnt[p*CW +: CW]    = m_cnt[p];
            exp_cnt_s[p*CWS +: CWS] = 3'(m_cnt[p] % 8);
        end
        #1;
    endtask

    task automatic set_wm(input int p, input int h, input int l);
        hi[p*LW +: LW] = 16'(h);
        lo[p*LW +: LW] = 16'(l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = '1; frc = '0; lvl = '0; hold = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp += 3;
            if (drop !== '0) begin n_bad++; $display("FAIL reset.drop c=%0d got=%b exp=0", c, drop); end
            if (pstate !== '0) begin n_bad++; $display("FAIL reset.state c=%0d got=%h exp=0", c, pstate); end
            if (ecount !== '0 || ecount_s !== '0) begin n_bad++; $display("FAIL reset.count c=%0d got=%h/%h exp=0", c, ecount, ecount_s); end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        en = '1; hold = 16'd0; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        for (int c = 0; c < 30; c++) begin
            if (c == 10) lvl[0 +: LW] = 16'd100;
            if (c == 20) lvl[0 +: LW] = 16'd40;
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL basic.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL basic.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL basic.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL basic.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
            n_cmp++;
            if (drop[0] !== (c >= 10 && c < 20)) begin n_bad++; $display("FAIL basic.drop0 c=%0d got=%b exp=%b", c, drop[0], (c >= 10 && c < 20)); end
        end
        n_cmp++;
        if (ecount[0 +: CW] !== 32'd1) begin n_bad++; $display("FAIL basic.episodes got=%0d exp=1", ecount[0 +: CW]); end
    endtask

    task automatic test_hold();
        do_reset();
        en = '1; hold = 16'd5; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        for (int c = 0; c < 32; c++) begin
            if (c == 10) lvl[0 +: LW] = 16'd100;
            if (c == 20) lvl[0 +: LW] = 16'd40;
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL hold.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL hold.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL hold.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL hold.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
            n_cmp++;
            if (drop[0] !== (c >= 10 && c <= 24)) begin n_bad++; $display("FAIL hold.drop0 c=%0d got=%b exp=%b", c, drop[0], (c >= 10 && c <= 24)); end
            if (c >= 20 && c <= 24) begin
                n_cmp++;
                if (pstate[1:0] !== 2'd2) begin n_bad++; $display("FAIL hold.in_hold c=%0d got=%0d exp=2", c, pstate[1:0]); end
            end
        end
        n_cmp++;
        if (ecount[0 +: CW] !== 32'd1) begin n_bad++; $display("FAIL hold.episodes got=%0d exp=1", ecount[0 +: CW]); end
    endtask

    task automatic test_reenter();
        do_reset();
        en = '1; hold = 16'd5; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        for (int c = 0; c < 22; c++) begin
            if (c == 5)  lvl[0 +: LW] = 16'd100;
            if (c == 8)  lvl[0 +: LW] = 16'd40;
            if (c == 11) lvl[0 +: LW] = 16'd120;
            if (c == 14) begin lvl[0 +: LW] = 16'd40; hold = 16'd0; end
            if (c == 17) lvl[0 +: LW] = 16'd100;
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL reenter.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL reenter.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL reenter.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL reenter.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
            if (c == 11) begin
                n_cmp++;
                if (pstate[1:0] !== 2'd1 || drop[0] !== 1'b1 || ecount[0 +: CW] !== 32'd1) begin
                    n_bad++; $display("FAIL reenter.hold_to_drop got=st%0d/d%b/n%0d exp=st1/d1/n1", pstate[1:0], drop[0], ecount[0 +: CW]);
                end
            end
        end
        n_cmp++;
        if (ecount[0 +: CW] !== 32'd2) begin n_bad++; $display("FAIL reenter.episodes got=%0d exp=2", ecount[0 +: CW]); end
    endtask

    task automatic test_force();
        do_reset();
        en = 4'b1011; frc = 4'b0100; hold = 16'd3; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) lvl[2*LW +: LW] = 16'd200;
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL force.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL force.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL force.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL force.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
            n_cmp += 2;
            if (drop !== 4'b0100) begin n_bad++; $display("FAIL force.vector c=%0d got=%b exp=0100", c, drop); end
            if (pstate[5:4] !== 2'd0 || ecount[2*CW +: CW] !== 32'd0) begin
                n_bad++; $display("FAIL force.port2 c=%0d got=st%0d/n%0d exp=st0/n0", c, pstate[5:4], ecount[2*CW +: CW]);
            end
        end
        frc = '0;
    endtask

    task automatic test_disable_reset();
        do_reset();
        en = '1; frc = '0; hold = 16'd10; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) lvl[0 +: LW] = 16'd100;
            if (c == 3) en[0] = 1'b0;
            if (c == 4) en[0] = 1'b1;
            if (c == 6) begin lvl[0 +: LW] = 16'd40; lvl[LW +: LW] = 16'd120; end
            if (c == 8) rst = 1'b1;
            if (c == 9) rst = 1'b0;
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL disrst.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL disrst.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL disrst.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL disrst.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
            if (c == 3) begin
                n_cmp++;
                if (drop[0] !== 1'b0 || pstate[1:0] !== 2'd0) begin
                    n_bad++; $display("FAIL disrst.disable got=d%b/st%0d exp=d0/st0", drop[0], pstate[1:0]);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (pstate[1:0] !== 2'd2 || pstate[3:2] !== 2'd1) begin
                    n_bad++; $display("FAIL disrst.prearm got=%h exp=st0=2,st1=1", pstate);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (drop !== '0 || pstate !== '0 || ecount !== '0) begin
                    n_bad++; $display("FAIL disrst.reset got=%b/%h/%h exp=all0", drop, pstate, ecount);
                end
            end
        end
    endtask

    task automatic test_misconfig();
        do_reset();
        en = '1; frc = '0; hold = 16'd0; lvl = '0;
        for (int p = 0; p < NP; p++) set_wm(p, 100, 40);
        set_wm(3, 50, 100);
        lvl[3*LW +: LW] = 16'd60;
        for (int k = 0; k < 40; k++) begin
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL misconf.drop k=%0d got=%b exp=%b", k, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL misconf.state k=%0d got=%h exp=%h", k, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL misconf.count k=%0d got=%h exp=%h", k, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL misconf.count_s k=%0d got=%h exp=%h", k, ecount_s, exp_cnt_s); end
            n_cmp += 3;
            if (drop[3] !== (k % 2 == 0)) begin n_bad++; $display("FAIL misconf.toggle k=%0d got=%b exp=%b", k, drop[3], (k % 2 == 0)); end
            if (ecount[3*CW +: CW] !== 32'(k / 2 + 1)) begin n_bad++; $display("FAIL misconf.episodes k=%0d got=%0d exp=%0d", k, ecount[3*CW +: CW], k / 2 + 1); end
            if (ecount_s[3*CWS +: CWS] !== 3'((k / 2 + 1) % 8)) begin
                n_bad++; $display("FAIL misconf.wrap k=%0d got=%0d exp=%0d", k, ecount_s[3*CWS +: CWS], (k / 2 + 1) % 8);
            end
        end
    endtask

    task automatic test_random();
        int lv[NP];
        do_reset();
        en = '1; frc = '0; hold = 16'd3;
        for (int p = 0; p < NP; p++) begin
            set_wm(p, 100, 40);
            lv[p] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NP; p++) begin
                lv[p] = lv[p] + int'($urandom_range(0, 24)) - 12;
                if (lv[p] < 0) lv[p] = 0;
                if (lv[p] > 200) lv[p] = 200;
                lvl[p*LW +: LW] = 16'(lv[p]);
                if ($urandom_range(0, 99) == 0) en[p] = ~en[p];
                if ($urandom_range(0, 79) == 0) frc[p] = ~frc[p];
                if ($urandom_range(0, 149) == 0)
                    set_wm(p, int'($urandom_range(40, 160)), int'($urandom_range(0, 120)));
            end
            if ($urandom_range(0, 199) == 0) hold = 16'($urandom_range(0, 8));
            rst = ($urandom_range(0, 799) == 0);
            step();
            n_cmp += 4;
            if (drop !== exp_drop) begin n_bad++; $display("FAIL random.drop c=%0d got=%b exp=%b", c, drop, exp_drop); end
            if (pstate !== exp_state) begin n_bad++; $display("FAIL random.state c=%0d got=%h exp=%h", c, pstate, exp_state); end
            if (ecount !== exp_cnt) begin n_bad++; $display("FAIL random.count c=%0d got=%h exp=%h", c, ecount, exp_cnt); end
            if (ecount_s !== exp_cnt_s) begin n_bad++; $display("FAIL random.count_s c=%0d got=%h exp=%h", c, ecount_s, exp_cnt_s); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_hold();
        test_reenter();
        test_force();
        test_disable_reset();
        test_misconfig();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
